// File: rtl/rtc_ctrl_pkg.sv
// Shared types and constant tables for the RTC user-control front end.
package rtc_ctrl_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Modification applied to the register under the cursor.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2
    } op_t;

    // Register group selected by the switches.
    typedef enum logic [1:0] {
        GRP_TIME  = 2'd0,
        GRP_DATE  = 2'd1,
        GRP_TIMER = 2'd2
    } group_t;

    // First local register index of each group; a group spans three indices.
    function automatic logic [3:0] group_base(input group_t g);
        case (g)
            GRP_DATE:  return 4'd4;
            GRP_TIMER: return 4'd7;
            default:   return 4'd1;
        endcase
    endfunction

    // Local index to RTC bus address.
    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h21;
            4'd2:    return 8'h22;
            4'd3:    return 8'h23;
            4'd4:    return 8'h24;
            4'd5:    return 8'h25;
            4'd6:    return 8'h26;
            4'd7:    return 8'h41;
            4'd8:    return 8'h42;
            4'd9:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    // Smallest legal BCD value; only day and month start at 1.
    function automatic logic [7:0] bcd_min(input logic [3:0] idx);
        case (idx)
            4'd4, 4'd5: return 8'h01;
            default:    return 8'h00;
        endcase
    endfunction

    // Largest legal BCD value.
    function automatic logic [7:0] bcd_max(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd2, 4'd7, 4'd8: return 8'h59;
            4'd3, 4'd9:             return 8'h23;
            4'd4:                   return 8'h31;
            4'd5:                   return 8'h12;
            4'd6:                   return 8'h99;
            default:                return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational wrapped BCD increment/decrement between min and max.
// Malformed inputs (a nibble above 9 or outside [min,max]) snap to min.
module bcd_step
    import rtc_ctrl_pkg::*;
(
    input  logic [7:0] value_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    input  op_t        op_i,
    output logic [7:0] result_o
);

    logic [3:0] hi;
    logic [3:0] lo;
    logic       valid;

    // Validate the input, then step one BCD unit with wrap-around.
    always_comb begin
        hi       = value_i[7:4];
        lo       = value_i[3:0];
        valid    = (hi <= 4'd9) && (lo <= 4'd9) &&
                   (value_i <= max_i) && (value_i >= min_i);
        result_o = value_i;
        case (op_i)
            OP_INC: begin
                if (!valid || value_i == max_i) result_o = min_i;
                else if (lo == 4'd9)            result_o = {hi + 4'd1, 4'd0};
                else                            result_o = {hi, lo + 4'd1};
            end
            OP_DEC: begin
                if (!valid)                     result_o = min_i;
                else if (value_i == min_i)      result_o = max_i;
                else if (lo == 4'd0)            result_o = {hi - 4'd1, 4'd9};
                else                            result_o = {hi, lo - 4'd1};
            end
            default: result_o = value_i;
        endcase
    end

endmodule

// File: rtl/control_de_usuario.sv
// User-control front end: turns button presses and group switches into
// read-modify-write sweeps over three RTC registers, handshaking with the
// master through Maquina_in/Maquina_out and fin.
//
// Handshake: the master holds Maquina_in high to request a sweep. Each
// transfer is presented (read=1, ADD/ADD2 stable) until the master pulses fin
// for one cycle; Dato_in is the register value and Dato_out/escritura are
// valid combinationally in that same cycle. After the third fin Maquina_out
// rises and stays high until Maquina_in is seen low.
module control_de_usuario
    import rtc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] selectores,
    input  logic [2:0] interruptores,
    input  logic       fin,
    input  logic       Maquina_in,
    output logic       Maquina_out,
    output logic [3:0] ADD,
    output logic [7:0] ADD2,
    output logic       read,
    input  logic [7:0] Dato_in,
    output logic [7:0] Dato_out,
    output logic       escritura,
    output logic [1:0] estado_dbg
);

    state_t     state_q, state_d;
    logic [1:0] field_q, field_d;
    logic [3:0] sel_q;
    logic [1:0] cursor_q, cursor_d;
    op_t        pend_op_q, pend_op_d;
    group_t     grp_prev_q;
    group_t     grp_lat_q;
    op_t        op_lat_q;
    logic [1:0] cur_lat_q;

    group_t     grp_now;
    logic       ro_now;
    logic [3:0] edges;
    logic       start;
    logic [3:0] idx;
    logic [7:0] stepped;
    logic       hit;

    assign edges      = selectores & ~sel_q;
    assign start      = (state_q == ST_IDLE) && Maquina_in;
    assign idx        = group_base(grp_lat_q) + {2'b00, field_q};
    assign estado_dbg = state_q;

    // Decode the switches: [0] > [1] > [2]; none set is read-only time.
    always_comb begin
        grp_now = GRP_TIME;
        ro_now  = 1'b0;
        if (interruptores[0])      grp_now = GRP_TIME;
        else if (interruptores[1]) grp_now = GRP_DATE;
        else if (interruptores[2]) grp_now = GRP_TIMER;
        else                       ro_now  = 1'b1;
    end

    // Pending op and cursor updates from button edges.
    always_comb begin
        pend_op_d = pend_op_q;
        cursor_d  = cursor_q;
        if (start)         pend_op_d = OP_NONE;
        if (edges[1])      pend_op_d = OP_DEC;
        else if (edges[0]) pend_op_d = OP_INC;
        if (grp_now != grp_prev_q) begin
            cursor_d = 2'd0;
        end else if (edges[2] && !edges[3]) begin
            cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
        end else if (edges[3] && !edges[2]) begin
            cursor_d = (cursor_q >= 2'd2) ? 2'd0 : cursor_q + 2'd1;
        end
    end

    // Front-end registers: button history, cursor, pending op, last group.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sel_q      <= 4'd0;
            cursor_q   <= 2'd0;
            pend_op_q  <= OP_NONE;
            grp_prev_q <= GRP_TIME;
        end else begin
            sel_q      <= selectores;
            cursor_q   <= cursor_d;
            pend_op_q  <= pend_op_d;
            grp_prev_q <= grp_now;
        end
    end

    // Sweep context captured at start so mid-sweep presses only affect the next sweep.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            grp_lat_q <= GRP_TIME;
            op_lat_q  <= OP_NONE;
            cur_lat_q <= 2'd0;
        end else if (start) begin
            grp_lat_q <= grp_now;
            op_lat_q  <= ro_now ? OP_NONE : pend_op_q;
            cur_lat_q <= cursor_q;
        end
    end

    // Sequencer state and field registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            field_q <= 2'd0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
        end
    end

    bcd_step u_bcd_step (
        .value_i  (Dato_in),
        .min_i    (bcd_min(idx)),
        .max_i    (bcd_max(idx)),
        .op_i     (op_lat_q),
        .result_o (stepped)
    );

    // Next state and transfer outputs; everything idles at zero outside XFER.
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        Maquina_out = 1'b0;
        ADD         = 4'd0;
        ADD2        = 8'h00;
        read        = 1'b0;
        Dato_out    = 8'h00;
        escritura   = 1'b0;
        hit         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Maquina_in) begin
                    state_d = ST_XFER;
                    field_d = 2'd0;
                end
            end
            ST_XFER: begin
                hit       = (field_q == cur_lat_q) && (op_lat_q != OP_NONE);
                ADD       = idx;
                ADD2      = addr_of(idx);
                read      = 1'b1;
                Dato_out  = hit ? stepped : Dato_in;
                escritura = hit;
                if (fin) begin
                    if (field_q >= 2'd2) state_d = ST_DONE;
                    else                 field_d = field_q + 2'd1;
                end
            end
            ST_DONE: begin
                Maquina_out = 1'b1;
                if (!Maquina_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_de_usuario.sv
// Directed bench for control_de_usuario with a queue-based transfer scoreboard.
module tb_control_de_usuario;

  logic       CLK;
  logic       reset;
  logic [3:0] selectores;
  logic [2:0] interruptores;
  logic       fin;
  logic       Maquina_in;
  logic       Maquina_out;
  logic [3:0] ADD;
  logic [7:0] ADD2;
  logic       read;
  logic [7:0] Dato_in;
  logic [7:0] Dato_out;
  logic       escritura;
  logic [1:0] estado_dbg;

  int errors = 0;
  int checks = 0;

  // {ADD, ADD2, Dato_out, escritura}
  logic [20:0] exp_q[$];

  control_de_usuario dut (
    .CLK           (CLK),
    .reset         (reset),
    .selectores    (selectores),
    .interruptores (interruptores),
    .fin           (fin),
    .Maquina_in    (Maquina_in),
    .Maquina_out   (Maquina_out),
    .ADD           (ADD),
    .ADD2          (ADD2),
    .read          (read),
    .Dato_in       (Dato_in),
    .Dato_out      (Dato_out),
    .escritura     (escritura),
    .estado_dbg    (estado_dbg)
  );

  // clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one expected entry per fin-acknowledged transfer
  always @(negedge CLK) begin
    if (fin === 1'b1 && read === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got 0x%0h expected none", {ADD, ADD2, Dato_out, escritura});
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        chk("xfer", {11'd0, ADD, ADD2, Dato_out, escritura}, {11'd0, e});
      end
    end
  end

  task automatic press(input int b);
    @(posedge CLK); #1 selectores[b] = 1'b1;
    repeat (2) @(posedge CLK);
    #1 selectores = 4'd0;
    @(posedge CLK); #1;
  endtask

  task automatic set_sw(input logic [2:0] sw);
    @(posedge CLK); #1 interruptores = sw;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  // full sweep: three transfers with hand-computed expected data and write flags
  task automatic sweep(input logic [3:0] base, input logic [7:0] abase,
                       input logic [23:0] din, input logic [23:0] dexp, input logic [2:0] wr);
    @(posedge CLK); #1 Maquina_in = 1'b1;
    @(posedge CLK); #1;
    chk("start_read", {31'd0, read}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({base + 4'(i), abase + 8'(i), dexp[23-8*i -: 8], wr[2-i]});
      Dato_in = din[23-8*i -: 8];
      fin = 1'b1;
      @(posedge CLK); #1;
    end
    fin = 1'b0;
    chk("done_after_last_fin", {31'd0, Maquina_out}, 32'd1);
    chk("read_low_in_done", {31'd0, read}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 chk("done_hold", {31'd0, Maquina_out}, 32'd1);
    Maquina_in = 1'b0;
    @(posedge CLK); #1;
    chk("release", {31'd0, Maquina_out}, 32'd0);
    chk("dato_out_idle", {24'd0, Dato_out}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    selectores = 4'd0;
    interruptores = 3'b000;
    fin = 1'b0;
    Maquina_in = 1'b0;
    Dato_in = 8'h00;
    #12;
    chk("rst_maquina_out", {31'd0, Maquina_out}, 32'd0);
    chk("rst_add", {28'd0, ADD}, 32'd0);
    chk("rst_add2", {24'd0, ADD2}, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_escritura", {31'd0, escritura}, 32'd0);
    chk("rst_dato_out", {24'd0, Dato_out}, 32'd0);
    @(negedge CLK) reset = 1'b1;

    // time group, cursor 0, INC: sec 59 wraps to 00
    set_sw(3'b001);
    press(0);
    sweep(4'd1, 8'h21, {8'h59, 8'h30, 8'h12}, {8'h00, 8'h30, 8'h12}, 3'b100);

    // fin while idle is ignored
    fin = 1'b1; @(posedge CLK); #1 fin = 1'b0;
    chk("idle_fin_read", {31'd0, read}, 32'd0);
    chk("idle_fin_done", {31'd0, Maquina_out}, 32'd0);

    // op consumed: second sweep unmodified
    sweep(4'd1, 8'h21, {8'h10, 8'h20, 8'h05}, {8'h10, 8'h20, 8'h05}, 3'b000);

    // date group, cursor 2, DEC: year 00 -> 99
    set_sw(3'b010);
    press(3); press(3); press(1);
    sweep(4'd4, 8'h24, {8'h15, 8'h07, 8'h00}, {8'h15, 8'h07, 8'h99}, 3'b001);

    // cursor 1, DEC: month 01 -> 12
    press(2); press(1);
    sweep(4'd4, 8'h24, {8'h20, 8'h01, 8'h24}, {8'h20, 8'h12, 8'h24}, 3'b010);

    // cursor 0, INC: day 31 -> 01
    press(2); press(0);
    sweep(4'd4, 8'h24, {8'h31, 8'h05, 8'h24}, {8'h01, 8'h05, 8'h24}, 3'b100);

    // timer group resets cursor; left wraps 0 -> 2; INC: hour 23 -> 00
    set_sw(3'b100);
    press(2); press(0);
    sweep(4'd7, 8'h41, {8'h45, 8'h59, 8'h23}, {8'h45, 8'h59, 8'h00}, 3'b001);

    // read-only: pending INC ignored
    set_sw(3'b000);
    press(0);
    sweep(4'd1, 8'h21, {8'h59, 8'h59, 8'h23}, {8'h59, 8'h59, 8'h23}, 3'b000);

    // malformed min 7A with DEC -> 00
    set_sw(3'b001);
    press(3); press(1);
    sweep(4'd1, 8'h21, {8'h00, 8'h7A, 8'h00}, {8'h00, 8'h00, 8'h00}, 3'b010);

    // right wraps 2 -> 0; INC with BCD carry 09 -> 10
    press(3); press(3); press(0);
    sweep(4'd1, 8'h21, {8'h09, 8'h00, 8'h00}, {8'h10, 8'h00, 8'h00}, 3'b100);

    // latest edge wins (up then down): sec 00 -> 59
    press(0); press(1);
    sweep(4'd1, 8'h21, {8'h00, 8'h11, 8'h22}, {8'h59, 8'h11, 8'h22}, 3'b100);

    // reset in XFER: asynchronous return to reset values
    press(0);
    @(posedge CLK); #1 Maquina_in = 1'b1;
    @(posedge CLK); #1;
    chk("pre_reset_read", {31'd0, read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_read", {31'd0, read}, 32'd0);
    chk("async_rst_add", {28'd0, ADD}, 32'd0);
    chk("async_rst_add2", {24'd0, ADD2}, 32'd0);
    chk("async_rst_escritura", {31'd0, escritura}, 32'd0);
    chk("async_rst_maquina_out", {31'd0, Maquina_out}, 32'd0);
    Maquina_in = 1'b0;
    @(negedge CLK) reset = 1'b1;
    @(posedge CLK); #1;
    sweep(4'd1, 8'h21, {8'h59, 8'h30, 8'h12}, {8'h59, 8'h30, 8'h12}, 3'b000);

    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end

endmodule

// File: doc/control_de_usuario.md
# control_de_usuario

User-control front end of the VGA real-time-clock project. Converts push-button (`selectores`) and switch (`interruptores`) inputs into read-modify-write sweeps over the RTC register file. A sweep covers the time, date or timer group and is started and acknowledged through a handshake with the master state machine. Each register is read, optionally incremented or decremented in BCD, and handed back together with its RTC bus address.

## Interface
Parameters: none. The address table and BCD limits are fixed constants.
- `CLK` in 1: the single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `selectores` in 4: push-buttons. [0] up, [1] down, [2] left, [3] right.
- `interruptores` in 3: group select. [0] time, [1] date, [2] timer. Priority [0] > [1] > [2]. None set means time group, read-only.
- `fin` in 1: one-cycle pulse from the master; the current register transfer is complete.
- `Maquina_in` in 1: sweep request from the master (level).
- `Maquina_out` out 1: sweep done; held high until `Maquina_in` falls.
- `ADD` out 4: local register index of the current transfer.
- `ADD2` out 8: RTC bus address of the current transfer.
- `read` out 1: high during every transfer.
- `Dato_in` in 8: BCD register value for `ADD`, supplied by the master.
- `Dato_out` out 8: value to write back.
- `escritura` out 1: high only during a transfer whose value is modified.

## Operation
- **Index and address map:**
  - Time group: 1→0x21 sec, 2→0x22 min, 3→0x23 hour.
  - Date group: 4→0x24 day, 5→0x25 month, 6→0x26 year.
  - Timer group: 7→0x41 sec, 8→0x42 min, 9→0x43 hour.
- **Button edges:** each button is rising-edge detected, one event per press.
  - Up or down edge sets the pending op to INC or DEC; the latest edge wins.
  - Left or right edge moves the cursor 0..2 with wrap-around (left from 0 goes to 2, right from 2 goes to 0).
- **Cursor reset:** the cursor returns to 0 whenever the active group changes.
- **Read-only mode:** when no switch is set, the pending op is ignored during the sweep.
- **FSM states:**
  - IDLE: on `Maquina_in`=1, latch the group, latch and clear the pending op, set field 0, go to XFER.
  - XFER: drive `ADD`, `ADD2`, `read`=1. `fin`=1 with field<2 increments the field. `fin`=1 with field=2 goes to DONE.
  - DONE: `Maquina_out`=1. When `Maquina_in`=0, go to IDLE.
- **Data path (combinational from `Dato_in`):**
  - A field equal to the cursor with a latched op gets INC or DEC applied; otherwise `Dato_out` = `Dato_in`.
  - BCD limits: sec/min 00–59, hour 00–23, day 01–31, month 01–12, year 00–99.
  - INC at max gives min; DEC at min gives max.
  - Input above max, or with a nibble above 9: INC and DEC both return min.
- **`escritura`:** equals (XFER and cursor field and op latched and not read-only).
- **Ignored inputs:** `fin` in IDLE or DONE; button events during a sweep update only the next sweep's pending op and cursor.

## Timing
- **Reset values:** state IDLE, `Maquina_out`=0, `ADD`=0, `ADD2`=0, `read`=0, `escritura`=0, `Dato_out`=0 (driven 0 outside XFER), cursor 0, pending op none.
- **Sweep start:** `Maquina_in` sampled high in IDLE gives `ADD`/`ADD2` valid at the next edge, i.e. 1-cycle latency.
- **Data path:** `Dato_out` follows `Dato_in` with zero clock latency and is valid before the next rising edge.
- **Last transfer:** `fin` on the last field gives `Maquina_out`=1 one cycle later.
- **Release:** `Maquina_out` drops one cycle after `Maquina_in` is sampled low.
- **Reset mid-sweep:** immediate return to IDLE; the latched op is discarded.

## Structure
- Shared package `rtc_ctrl_pkg` holds:
  - state enum (IDLE/XFER/DONE);
  - op enum (NONE/INC/DEC);
  - group enum;
  - index→address table;
  - BCD min/max per index.
- One sub-module `bcd_step`: combinational; inputs value, min, max, op; output the wrapped BCD result.

## Test plan
- `interruptores`=001, cursor 0, up press, sweep with sec=0x59 → `Dato_out`=0x00, `escritura`=1 on index 1 only; min/hour pass through unchanged; `Maquina_out`=1 after third `fin`.
- `interruptores`=010, right press twice, down press, year=0x00 → `ADD`=6, `ADD2`=0x26, `Dato_out`=0x99.
- Month 0x01 with DEC → 0x12. Day 0x31 with INC → 0x01. Hour 0x23 with INC → 0x00.
- `interruptores`=000 with pending INC → indices 1–3 swept, `Dato_out`=`Dato_in`, `escritura` never high.
- Second sweep without new presses → no modification (op consumed). `Maquina_out` holds until `Maquina_in` low.
- Reset asserted in XFER → all outputs at reset values asynchronously; next sweep starts at index 1.
